// File: rtl/pwm_capture_if.sv
// Port bundle for pwm_capture: the enable and raw PWM input going in, the
// measured period/high time and the result strobes coming out.
interface pwm_capture_if #(
    parameter int CNT_BITS = 16
);
    logic                enable;
    logic                pwm_in;
    logic [CNT_BITS-1:0] period;
    logic [CNT_BITS-1:0] high_time;
    logic                valid;
    logic                overflow;

    modport master (
        output enable,
        output pwm_in,
        input  period,
        input  high_time,
        input  valid,
        input  overflow
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output period,
        output high_time,
        output valid,
        output overflow
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM measurement: synchronises an asynchronous PWM input and reports the
// period and high time of every complete cycle, in clk cycles.
module pwm_capture #(
    parameter int CNT_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    pwm_capture_if.slave bus
);

    typedef enum logic {
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic                   pwm_d;
    logic                   rise;

    state_t              state, state_n;
    logic [CNT_BITS-1:0] cnt, cnt_n;
    logic [CNT_BITS-1:0] hi_cnt, hi_cnt_n;
    logic [CNT_BITS-1:0] period_q, period_n;
    logic [CNT_BITS-1:0] high_q, high_n;
    logic                valid_q, valid_n;
    logic                overflow_q, overflow_n;

    // Synchroniser and edge-detect flop run independently of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d;

    always_comb begin
        // NOTE: every next-value signal is defaulted first so that no branch
        // leaves one unassigned, which would otherwise infer a latch.
        state_n    = state;
        cnt_n      = cnt;
        hi_cnt_n   = hi_cnt;
        period_n   = period_q;
        high_n     = high_q;
        valid_n    = 1'b0;
        overflow_n = 1'b0;

        if (!bus.enable) begin
            // Abort and re-arm; the last published result is kept.
            state_n  = ARM;
            cnt_n    = '0;
            hi_cnt_n = '0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        cnt_n    = CNT_ONE;
                        hi_cnt_n = CNT_ONE;
                        state_n  = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_n = cnt;
                        high_n   = hi_cnt;
                        valid_n  = 1'b1;
                        cnt_n    = CNT_ONE;
                        hi_cnt_n = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        overflow_n = 1'b1;
                        state_n    = ARM;
                    end else begin
                        // hi_cnt never passes cnt, so only cnt needs the limit.
                        cnt_n = cnt + CNT_ONE;
                        if (pwm_s) begin
                            hi_cnt_n = hi_cnt + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register load from the
        // values present before the edge, independent of statement order.
        if (reset) begin
            state      <= ARM;
            cnt        <= '0;
            hi_cnt     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hi_cnt     <= hi_cnt_n;
            period_q   <= period_n;
            high_q     <= high_n;
            valid_q    <= valid_n;
            overflow_q <= overflow_n;
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: it reports the period and the high time of each complete cycle, counted in `clk` cycles. It is the receive-side counterpart of the timer-driven PWM generator. Typical uses are loopback self-check of the generator output and measuring external PWM sources. The input is asynchronous; it is synchronised internally, and results are published with a one-cycle `valid` strobe.

## Interface

Parameters:
- `CNT_BITS`, default 16: width of the internal counters and of `period`/`high_time`. The maximum measurable period is 2^CNT_BITS−1 clocks.
- `SYNC_STAGES`, default 2: number of flip-flops in the input synchroniser. Legal values are ≥2.

Ports:
- `clk`, input, 1 bit: single clock; all logic is rising-edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `enable`, input, 1 bit: when high, the block measures; when low, it aborts and re-arms.
- `pwm_in`, input, 1 bit: asynchronous PWM input.
- `period`, output, CNT_BITS bits: clocks from one synchronised rising edge to the next.
- `high_time`, output, CNT_BITS bits: clocks during which the synchronised input was high within that period.
- `valid`, output, 1 bit: one-cycle pulse; `period` and `high_time` were updated on the same edge.
- `overflow`, output, 1 bit: one-cycle pulse; the period counter saturated and the measurement was discarded.

## Operation

- **Synchroniser.** `pwm_in` passes through SYNC_STAGES flops; the last stage is called `pwm_s`. A further flop `pwm_d` registers `pwm_s`. The edge detect is `rise = pwm_s & ~pwm_d`. The synchroniser runs regardless of `enable`.
- **FSM states.**
  - ARM: waiting for the first rising edge.
  - MEASURE: counting.
- **Counters.** `cnt` counts period clocks and `hi_cnt` counts high clocks; both are CNT_BITS wide and unsigned.
- **ARM state.**
  - On `rise`: set cnt←1 and hi_cnt←1, then go to MEASURE. No `valid` is produced, so the first partial period is always discarded.
- **MEASURE state**, each cycle, in priority order:
  1. `rise`: set period←cnt, high_time←hi_cnt, valid←1, cnt←1, hi_cnt←1. Stay in MEASURE.
  2. No `rise` and cnt == 2^CNT_BITS−1: set overflow←1 and go to ARM. `period` and `high_time` are unchanged.
  3. Otherwise: cnt←cnt+1. If `pwm_s` is high, hi_cnt←hi_cnt+1.
- **Invariants.**
  - high_time ≤ period, and period ≥ 1.
  - Duty is high_time/period; the block does no division.
  - hi_cnt can never exceed cnt, so it needs no separate saturation.
- **Constant input (0% or 100% duty) after a rise.** Exactly one `overflow` pulse, then the block stays in ARM until the next rising edge.
- **`enable` low** (takes priority over the FSM):
  - state←ARM, cnt←0, hi_cnt←0, valid←0, overflow←0.
  - `period` and `high_time` hold their last values.
  - A measurement in progress is discarded.
- **`enable` rising.** Starts in ARM. The first `valid` comes at the second rising edge seen while enabled.
- **`reset`** (highest priority, any state, mid-measurement included):
  - All synchroniser flops and `pwm_d` go to 0.
  - cnt, hi_cnt, period, high_time, valid and overflow go to 0; state goes to ARM.

## Timing

- Reset values:
  - period = 0, high_time = 0, valid = 0, overflow = 0; state ARM.
  - Visible on the first edge with `reset` high.
- Edge-to-`rise` latency: if `pwm_in` rises before clock edge e0, `pwm_s` is high after edge e(SYNC_STAGES−1). `rise` is asserted during the following cycle.
- `valid` is registered. It goes high one edge after the `rise` cycle, which is SYNC_STAGES+1 edges after `pwm_in` rises (3 for the default), and stays high for exactly one cycle.
- `valid` and `overflow` are never high in the same cycle.
- Consecutive `valid` pulses are spaced by exactly `period` cycles while the input is stable.
- Minimum measurable waveform: period 2, high_time 1 (input toggling every clock after synchronisation).
- Input pulses shorter than one clock may be missed. This is by design; no filtering is done.

## Test plan

1. **Reset.** Hold `reset` for 2 cycles with random `pwm_in` → period = 0, high_time = 0, valid = 0 and overflow = 0 throughout and on release.
2. **Steady PWM.** CNT_BITS = 16, `enable` = 1, pwm_in high 3 clocks / low 5 clocks, clock-aligned → no `valid` at the first rise. Then valid pulses every 8 cycles with period = 8 and high_time = 3. The first pulse comes SYNC_STAGES+1 edges after the second `pwm_in` rise.
3. **Minimum and narrow pulses.** High 1 / low 1 → period = 2, high_time = 1. High 1 / low 3 → period = 4, high_time = 1.
4. **Saturation.** CNT_BITS = 4, one rise, then `pwm_in` held high → exactly one `overflow` pulse, 15 cycles after the `rise` cycle, with no `valid`. A later 10/15-cycle waveform needs its second rise, then gives period = 15 and high_time = 10.
5. **Enable abort.** Drop `enable` for 1 cycle in mid-period of a 3/5 waveform → no `valid` for the aborted period, and outputs hold the last result. After re-enable, the first `valid` comes at the second subsequent rise, with period = 8.
6. **Reset mid-measurement.** Assert `reset` 4 cycles after a rise → all outputs are 0 on the next edge. After release, the behaviour matches scenario 2 from scratch.
